// File: rtl/proto245_pkg.sv
// ----------------------------------------------------------------------------
// proto245_pkg
// Shared types and constants for the FT245 synchronous-FIFO receive path.
//   rx_state_t : receive controller FSM encoding
//   FT_DATA_W  : width of the FTDI data bus
// ----------------------------------------------------------------------------
package proto245_pkg;

  localparam int FT_DATA_W = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_REQ,
    RX_TURN,
    RX_READ,
    RX_RELEASE
  } rx_state_t;

endpackage

// File: rtl/ft245_rx_ctrl.sv
// ----------------------------------------------------------------------------
// ft245_rx_ctrl
// FT245 synchronous-FIFO-mode receive controller in the FT clock domain.
// Pulls bytes from the FTDI chip and writes them into the write side of the
// async FIFO. It requests the shared data bus from the TX/RX arbiter and
// throttles on the FIFO fill level.
//
// Optional feature: define PROTO245_RX_STATS_EN to add rx_cnt / rx_ovf.
//
// Ports
//   wclk, wrst     FT clock (rising edge); synchronous active-high reset
//   ft_rxf_n       FTDI: 0 = RX data available
//   ft_data_i      FTDI data bus, input path
//   ft_oe_n        FTDI output enable, active-low, registered
//   ft_rd_n        FTDI read strobe, active-low, registered
//   arb_req        request for data-bus ownership
//   arb_gnt        bus granted to RX
//   fifo_wdata     byte to FIFO
//   fifo_wen       FIFO write strobe, one cycle per byte
//   fifo_wload     registered FIFO fill level (ADDR_W+1 bits)
//   fifo_wfull     FIFO full
//   fsm_state      current FSM state (rx_state_t encoding), for observation
//   rx_cnt         (stats) FIFO writes, wraps at 2^32
//   rx_ovf         (stats) sticky: a byte arrived while the FIFO was full
//
// Handshake: a byte moves from the FTDI chip at every rising edge where
// ft_rd_n==0 and ft_rxf_n==0; it appears on fifo_wdata with fifo_wen=1 during
// the following cycle. The FIFO has no ready; flow control is the fill level.
// ----------------------------------------------------------------------------
module ft245_rx_ctrl
  import proto245_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WORDS_TOTAL = 2**ADDR_W,
  parameter int HEADROOM    = 3,
  parameter int MAX_BURST   = 64
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 ft_rxf_n,
  input  logic [FT_DATA_W-1:0] ft_data_i,
  output logic                 ft_oe_n,
  output logic                 ft_rd_n,
  output logic                 arb_req,
  input  logic                 arb_gnt,
  output logic [FT_DATA_W-1:0] fifo_wdata,
  output logic                 fifo_wen,
  input  logic [ADDR_W:0]      fifo_wload,
  input  logic                 fifo_wfull,
  output logic [2:0]           fsm_state
`ifdef PROTO245_RX_STATS_EN
  ,
  output logic [31:0]          rx_cnt,
  output logic                 rx_ovf
`endif
);

  localparam logic [ADDR_W:0] WORDS_V = (ADDR_W+1)'(WORDS_TOTAL);
  localparam logic [ADDR_W:0] HEAD_V  = (ADDR_W+1)'(HEADROOM);
  localparam logic [7:0]      LAST_V  = 8'(MAX_BURST - 1);

  rx_state_t            state, state_nxt;
  logic [7:0]           burst_cnt, burst_cnt_nxt;
  logic                 oe_n_nxt, rd_n_nxt, req_nxt, wen_nxt;
  logic [FT_DATA_W-1:0] wdata_nxt;
  logic [ADDR_W:0]      free;
  logic                 space_ok;
  logic                 xfer;

  // wload lags by a register and one byte sits in the capture stage, so a
  // burst only runs while more than HEADROOM words are free.
  assign free     = WORDS_V - fifo_wload;
  assign space_ok = (free > HEAD_V);

  // ft_rd_n is only low in READ; the state term keeps the decode local.
  assign xfer = (state == RX_READ) && !ft_rd_n && !ft_rxf_n;

  assign fsm_state = state;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state      <= RX_IDLE;
      burst_cnt  <= '0;
      ft_oe_n    <= 1'b1;
      ft_rd_n    <= 1'b1;
      arb_req    <= 1'b0;
      fifo_wen   <= 1'b0;
      fifo_wdata <= '0;
    end else begin
      state      <= state_nxt;
      burst_cnt  <= burst_cnt_nxt;
      ft_oe_n    <= oe_n_nxt;
      ft_rd_n    <= rd_n_nxt;
      arb_req    <= req_nxt;
      fifo_wen   <= wen_nxt;
      fifo_wdata <= wdata_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    oe_n_nxt      = ft_oe_n;
    rd_n_nxt      = ft_rd_n;
    req_nxt       = arb_req;
    wen_nxt       = 1'b0;
    wdata_nxt     = fifo_wdata;
    case (state)
      RX_IDLE: begin
        if (!ft_rxf_n && space_ok) begin
          state_nxt = RX_REQ;
          req_nxt   = 1'b1;
        end
      end
      RX_REQ: begin
        // Losing data or space withdraws the request; a missing grant just waits.
        if (ft_rxf_n || !space_ok) begin
          state_nxt = RX_IDLE;
          req_nxt   = 1'b0;
        end else if (arb_gnt) begin
          state_nxt = RX_TURN;
          oe_n_nxt  = 1'b0;
        end
      end
      RX_TURN: begin
        if (!arb_gnt) begin
          state_nxt = RX_RELEASE;
          oe_n_nxt  = 1'b1;
        end else begin
          state_nxt = RX_READ;
          rd_n_nxt  = 1'b0;
        end
      end
      RX_READ: begin
        if (xfer) begin
          wdata_nxt     = ft_data_i;
          burst_cnt_nxt = burst_cnt + 8'd1;
`ifdef PROTO245_RX_STATS_EN
          wen_nxt       = !fifo_wfull;
`else
          wen_nxt       = 1'b1;
`endif
        end
        // The byte moved at the exit edge is kept; rd_n rises with the exit.
        if (ft_rxf_n || !space_ok || !arb_gnt ||
            (xfer && burst_cnt == LAST_V)) begin
          state_nxt = RX_RELEASE;
          rd_n_nxt  = 1'b1;
          oe_n_nxt  = 1'b1;
        end
      end
      RX_RELEASE: begin
        state_nxt     = RX_IDLE;
        req_nxt       = 1'b0;
        burst_cnt_nxt = '0;
      end
      default: begin
        state_nxt = RX_IDLE;
      end
    endcase
  end

`ifdef PROTO245_RX_STATS_EN
  always_ff @(posedge wclk) begin
    if (wrst) begin
      rx_cnt <= '0;
      rx_ovf <= 1'b0;
    end else begin
      if (fifo_wen) rx_cnt <= rx_cnt + 32'd1;
      if (xfer && fifo_wfull) rx_ovf <= 1'b1;
    end
  end
`else
  // Without the statistics block a full FIFO is never observed here.
  logic unused_wfull;
  assign unused_wfull = fifo_wfull;
`endif

endmodule

// File: tb/tb_ft245_rx_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ft245_rx_ctrl
// Bench for ft245_rx_ctrl. Behavioural models of the FTDI source, the FIFO
// fill level and the arbiter surround the DUT. Every byte offered by the FTDI
// model is queued as expected FIFO data; a monitor pops and compares on each
// fifo_wen. Build with PROTO245_RX_STATS_EN to also cover rx_cnt / rx_ovf.
// ----------------------------------------------------------------------------
module tb_ft245_rx_ctrl;
  import proto245_pkg::*;

  localparam int ADDR_W    = 4;
  localparam int WORDS     = 16;
  localparam int HEADROOM  = 3;
  localparam int MAX_BURST = 64;

  logic              wclk       = 1'b0;
  logic              wrst       = 1'b1;
  logic              ft_rxf_n   = 1'b1;
  logic [7:0]        ft_data_i  = '0;
  logic              arb_gnt    = 1'b0;
  logic [ADDR_W:0]   fifo_wload = '0;
  logic              fifo_wfull = 1'b0;
  logic              ft_oe_n, ft_rd_n, arb_req, fifo_wen;
  logic [7:0]        fifo_wdata;
  logic [2:0]        fsm_state;
`ifdef PROTO245_RX_STATS_EN
  logic [31:0]       rx_cnt;
  logic              rx_ovf;
`endif

  ft245_rx_ctrl #(
    .ADDR_W(ADDR_W), .WORDS_TOTAL(WORDS), .HEADROOM(HEADROOM), .MAX_BURST(MAX_BURST)
  ) dut (
    .wclk(wclk), .wrst(wrst), .ft_rxf_n(ft_rxf_n), .ft_data_i(ft_data_i),
    .ft_oe_n(ft_oe_n), .ft_rd_n(ft_rd_n), .arb_req(arb_req), .arb_gnt(arb_gnt),
    .fifo_wdata(fifo_wdata), .fifo_wen(fifo_wen), .fifo_wload(fifo_wload),
    .fifo_wfull(fifo_wfull), .fsm_state(fsm_state)
`ifdef PROTO245_RX_STATS_EN
    , .rx_cnt(rx_cnt), .rx_ovf(rx_ovf)
`endif
  );

  // ---------------- clock / cycle counter ----------------
  always #5 wclk = ~wclk;
  int cyc = 0;
  always @(posedge wclk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];   // bytes expected at the FIFO, in order
  logic [7:0] src_q[$];   // bytes still held by the FTDI model
  int bursts_q[$];        // bytes moved per rd_n-low window
  int wen_total   = 0;
  int delivered   = 0;
  int fill        = 0;

  // test knobs
  int drain_mode = 2;     // 0 stalled reader, 1 random reader, 2 reader every cycle
  int gap_cyc    = -100;  // cycle with rxf_n forced high
  int drop_cyc   = -100;  // first of three cycles with grant withheld
  int force_cyc  = -100;  // cycle with fifo_wfull forced high
  bit gnt_rand   = 1'b0;
  bit gap_check  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    src_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) push_byte(8'($urandom_range(0, 255)));
  endtask

  task automatic wait_rd_low(input string name, input int budget);
    int n = 0;
    @(negedge wclk);
    while (ft_rd_n && n < budget) begin
      @(negedge wclk);
      n++;
    end
    check({name, "_rd_low_seen"}, ft_rd_n, 1'b0);
  endtask

  task automatic wait_drained(input string name, input int budget);
    int n = 0;
    @(negedge wclk);
    while (n < budget && !(src_q.size() == 0 && exp_q.size() == 0 &&
                           fsm_state == RX_IDLE && ft_rd_n)) begin
      @(negedge wclk);
      n++;
    end
    check({name, "_src_left"}, src_q.size(), 0);
    check({name, "_exp_left"}, exp_q.size(), 0);
    check({name, "_state_idle"}, fsm_state, RX_IDLE);
  endtask

  // ---------------- FTDI source model ----------------
  // The chip hands over its head byte at any edge with RD#=0 and RXF#=0.
  // A byte handed over at a reset edge (or, with statistics, while the FIFO
  // reads full) never reaches the FIFO, so it leaves the expected queue.
  initial begin
    logic took, rst_s, full_s, lost;
    int idx;
    forever begin
      @(negedge wclk);
      took   = !ft_rd_n && !ft_rxf_n;
      rst_s  = wrst;
      full_s = fifo_wfull;
      @(posedge wclk);
      #1;
      if (took && src_q.size() > 0) begin
        lost = rst_s;
`ifdef PROTO245_RX_STATS_EN
        lost = lost || full_s;
`endif
        if (lost) begin
          idx = exp_q.size() - src_q.size();
          if (idx >= 0) exp_q.delete(idx);
        end else begin
          delivered++;
        end
        void'(src_q.pop_front());
      end
      ft_rxf_n  = (src_q.size() == 0) || (cyc == gap_cyc);
      ft_data_i = (src_q.size() > 0) ? src_q[0] : 8'($urandom_range(0, 255));
    end
  end

  // ---------------- FIFO fill model (registered wload) ----------------
  initial begin
    logic w;
    bit   pop;
    forever begin
      @(negedge wclk);
      w   = fifo_wen;
      pop = (fill > 0) && (drain_mode == 2 || (drain_mode == 1 && $urandom_range(0, 3) != 0));
      @(posedge wclk);
      #1;
      fill       = fill + int'(w) - int'(pop);
      fifo_wload = (fill > WORDS) ? (ADDR_W+1)'(WORDS) : (ADDR_W+1)'(fill);
      fifo_wfull = (fill >= WORDS) || (cyc == force_cyc);
    end
  end

  // ---------------- arbiter model ----------------
  initial begin
    logic req_s;
    forever begin
      @(negedge wclk);
      req_s = arb_req;
      @(posedge wclk);
      #1;
      arb_gnt = req_s && !(cyc >= drop_cyc && cyc < drop_cyc + 3) &&
                (!gnt_rand || $urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic prev_rd_n = 1'b1;
    int   cur_burst = 0;
    int   hi_run    = 0;
    forever begin
      @(negedge wclk);
      if (fifo_wen) begin
        wen_total++;
        check("wen_while_full", (fill >= WORDS), 1'b0);
        if (exp_q.size() == 0) check("unexpected_write", 1'b1, 1'b0);
        else                   check("fifo_wdata", fifo_wdata, exp_q.pop_front());
      end
      if (!ft_rd_n) check("oe_low_while_reading", ft_oe_n, 1'b0);
      if (!prev_rd_n && ft_rd_n) begin
        check("burst_within_max", (cur_burst <= MAX_BURST), 1'b1);
        bursts_q.push_back(cur_burst);
        cur_burst = 0;
      end
      if (prev_rd_n && !ft_rd_n) begin
        if (gap_check) check("turnaround_gap", (hi_run >= 4), 1'b1);
        hi_run = 0;
      end
      if (ft_rd_n) hi_run++;
      if (!ft_rd_n && !ft_rxf_n && !wrst) cur_burst++;
      prev_rd_n = ft_rd_n;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: actual still running, required finish by cycle 50000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base, rem, nb, len, sum;

    // reset state
    repeat (3) @(posedge wclk);
    @(negedge wclk);
    check("rst_oe_n", ft_oe_n, 1'b1);
    check("rst_rd_n", ft_rd_n, 1'b1);
    check("rst_arb_req", arb_req, 1'b0);
    check("rst_fifo_wen", fifo_wen, 1'b0);
    check("rst_fifo_wdata", fifo_wdata, 8'h00);
    check("rst_state", fsm_state, RX_IDLE);
`ifdef PROTO245_RX_STATS_EN
    check("rst_rx_cnt", rx_cnt, 32'd0);
    check("rst_rx_ovf", rx_ovf, 1'b0);
`endif
    @(posedge wclk);
    #1 wrst = 1'b0;

    // single byte: oe_n falls, rd_n one cycle later, one write of 0xA5
    @(negedge wclk);
    base = wen_total;
    push_byte(8'hA5);
    begin
      int n = 0;
      while (ft_oe_n && n < 50) begin
        @(negedge wclk);
        n++;
      end
    end
    check("single_oe_fell", ft_oe_n, 1'b0);
    check("single_turnaround_rd_n", ft_rd_n, 1'b1);
    @(negedge wclk);
    check("single_read_rd_n", ft_rd_n, 1'b0);
    check("single_read_oe_n", ft_oe_n, 1'b0);
    wait_drained("single", 100);
    check("single_write_count", wen_total - base, 1);
    check("single_req_dropped", arb_req, 1'b0);

    // long stream: 200 bytes, grant held, bursts capped at MAX_BURST
    base = bursts_q.size();
    gap_check = 1'b1;
    push_rand(200);
    wait_drained("long", 3000);
    gap_check = 1'b0;
    rem = 200;
    nb  = 0;
    while (rem > 0) begin
      len = (rem > MAX_BURST) ? MAX_BURST : rem;
      if (base + nb < bursts_q.size()) check("long_burst_len", bursts_q[base + nb], len);
      else                             check("long_burst_missing", 1'b0, 1'b1);
      rem -= len;
      nb++;
    end
    check("long_burst_count", bursts_q.size() - base, nb);

    // throttle: reader stalled, reading must stop short of full
    drain_mode = 0;
    push_rand(40);
    repeat (150) @(negedge wclk);
    check("throttle_rd_n_high", ft_rd_n, 1'b1);
    check("throttle_state_idle", fsm_state, RX_IDLE);
    check("throttle_reached_headroom", (fill >= WORDS - HEADROOM), 1'b1);
    check("throttle_no_overfill", (fill <= WORDS - 1), 1'b1);
`ifdef PROTO245_RX_STATS_EN
    check("throttle_rx_ovf", rx_ovf, 1'b0);
`endif
    drain_mode = 1;
    wait_drained("throttle", 2000);

    // rxf_n high for one cycle mid-burst: burst splits, nothing lost or repeated
    drain_mode = 2;
    base = bursts_q.size();
    push_rand(30);
    wait_rd_low("gap", 50);
    gap_cyc = cyc + 4;
    wait_drained("gap", 500);
    check("gap_burst_count", bursts_q.size() - base, 2);
    sum = 0;
    for (int i = base; i < bursts_q.size(); i++) sum += bursts_q[i];
    check("gap_burst_total", sum, 30);

    // grant withdrawn in READ: strobes high at the next edge
    push_rand(30);
    wait_rd_low("gnt_drop", 50);
    drop_cyc = cyc + 3;
    begin
      int n = 0;
      while (cyc != drop_cyc + 1 && n < 20) begin
        @(negedge wclk);
        n++;
      end
    end
    check("gnt_drop_rd_n", ft_rd_n, 1'b1);
    check("gnt_drop_oe_n", ft_oe_n, 1'b1);
    wait_drained("gnt_drop", 500);

`ifdef PROTO245_RX_STATS_EN
    // forced full during a transfer: byte dropped, overflow sticky
    push_rand(20);
    wait_rd_low("ovf", 50);
    force_cyc = cyc + 3;
    wait_drained("ovf", 500);
    check("ovf_set", rx_ovf, 1'b1);
    check("ovf_rx_cnt", rx_cnt, 32'(delivered));
    repeat (5) @(negedge wclk);
    check("ovf_sticky", rx_ovf, 1'b1);
`endif

    // random soak: random grant gaps, random reader, random rxf blips
    gnt_rand   = 1'b1;
    drain_mode = 1;
    for (int r = 0; r < 6; r++) begin
      push_rand($urandom_range(1, 60));
      gap_cyc = cyc + $urandom_range(2, 40);
      wait_drained("soak", 3000);
    end
    gnt_rand   = 1'b0;
    drain_mode = 2;

    // reset mid-burst: the byte taken at the reset edge is discarded
    push_rand(30);
    wait_rd_low("reset", 50);
    repeat (3) @(negedge wclk);
    @(posedge wclk);
    #1 wrst = 1'b1;
    @(posedge wclk);
    @(negedge wclk);
    check("midrst_rd_n", ft_rd_n, 1'b1);
    check("midrst_oe_n", ft_oe_n, 1'b1);
    check("midrst_arb_req", arb_req, 1'b0);
    check("midrst_fifo_wen", fifo_wen, 1'b0);
    check("midrst_fifo_wdata", fifo_wdata, 8'h00);
    check("midrst_state", fsm_state, RX_IDLE);
`ifdef PROTO245_RX_STATS_EN
    check("midrst_rx_cnt", rx_cnt, 32'd0);
    check("midrst_rx_ovf", rx_ovf, 1'b0);
`endif
    @(posedge wclk);
    #1 wrst = 1'b0;
    wait_drained("after_reset", 500);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
